adder_arbiter: RTL
==================

ADDER_ARBITER -- requirements
Module: adder_arbiter

Interface
REQ-001 Parameter: N_REQ, default 4, number of requesters sharing one beh_16bitadder instance (fixed at 4 for this release).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 req_valid  input  4  bit i = requester i presents an operand pair.
REQ-005 req_a  input  64  operand A, requester i at bits [16i+15:16i].
REQ-006 req_b  input  64  operand B, same packing as req_a.
REQ-007 req_ready  output  4  one-hot or zero; bit i = requester i's operands accepted this cycle.
REQ-008 rsp_valid  output  1  result held on rsp_* is valid.
REQ-009 rsp_ready  input  1  consumer accepts result.
REQ-010 rsp_id  output  2  index of the requester that owns the result.
REQ-011 rsp_sum  output  16  A+B modulo 2^16.
REQ-012 rsp_flags  output  5  {sign, zero, carry, parity, overflow} from the adder.
REQ-013 busy  output  1  high in any state other than IDLE.

Function
REQ-014 FSM states: IDLE, CALC, RESP.
REQ-015 IDLE: if any req_valid is set, assert req_ready for the granted index only, capture its req_a and req_b into operand registers and its index into rsp_id, then go to CALC; otherwise stay in IDLE.
REQ-016 req_ready is combinational from state, req_valid and the round-robin pointer, and is all-zero outside IDLE.
REQ-017 Grant is round-robin: choose the first set req_valid at or after pointer ptr, in modulo-4 order; after a grant to index g, ptr = (g+1) mod 4.
REQ-018 CALC: drive the registered operands into the adder, register the sum and the five flags, set rsp_valid, then go to RESP. Latency is 2 cycles from the req_ready edge to rsp_valid high.
REQ-019 RESP: hold rsp_valid, rsp_id, rsp_sum and rsp_flags stable until rsp_ready=1. On that edge, clear rsp_valid and return to IDLE.
REQ-020 A new grant occurs no earlier than the cycle after the rsp_ready handshake; throughput is at most one operation per 3 cycles.
REQ-021 Flag definitions:
  - sign = sum[15]
  - zero = (sum == 0)
  - carry = bit 16 of the unsigned add
  - parity = 1 when sum has an even number of ones
  - overflow = 1 when A[15]==B[15] and sum[15]!=A[15]
REQ-022 Changes on req_valid, req_a or req_b outside the accept cycle have no effect on the operation in flight.
REQ-023 rsp_ready while rsp_valid=0 is ignored.
REQ-024 All four requesters valid continuously: each is granted exactly once in any 4 consecutive grants (no starvation).

Reset
REQ-025 rst_n low immediately forces these values:
  - state=IDLE, ptr=0
  - rsp_valid=0, rsp_id=0, rsp_sum=0, rsp_flags=0
  - operand registers cleared; req_ready and busy therefore 0
REQ-026 Reset asserted in CALC or RESP discards the in-flight operation; no response is produced for it after reset releases.
REQ-027 The first grant after reset release goes to the lowest set req_valid index (ptr=0).

Structure
REQ-028 Shared package holds the state enum (IDLE, CALC, RESP), the FLAG_* bit-position constants (SIGN=4, ZERO=3, CARRY=2, PARITY=1, OVF=0) and N_REQ.
REQ-029 Exactly one sub-module, the existing beh_16bitadder, is instantiated once; the arbiter adds no second adder.

Verification
REQ-030 Requester 0 only, A=16'h8FFF, B=16'h8000, rsp_ready=1 -> 2 cycles later rsp_sum=16'h0FFF, rsp_flags=5'b00111, rsp_id=0.
REQ-031 Requester 2 only, A=16'hFFFE, B=16'h0002 -> rsp_sum=16'h0000, rsp_flags=5'b01110, rsp_id=2.
REQ-032 All 4 valid with distinct operands (requester 1: AAAA+5555), rsp_ready=1 -> grant order 0,1,2,3,0; requester 1 response rsp_sum=16'hFFFF, rsp_flags=5'b10010.
REQ-033 rsp_ready held 0 for 5 cycles in RESP with req_valid=4'b1111 -> rsp_* stable, req_ready=0 throughout; the next grant follows the cycle after rsp_ready=1.
REQ-034 rst_n pulsed low during CALC -> rsp_valid stays 0, busy=0, ptr=0; after release with req_valid=4'b1010, requester 1 is granted first.

Source files
------------

// File: rtl/adder_arbiter_pkg.sv
// Shared types and constants for the round-robin adder arbiter.
package adder_arbiter_pkg;

  localparam int unsigned N_REQ  = 4;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned ID_W   = 2;
  localparam int unsigned FLAG_W = 5;

  // Bit positions inside rsp_flags
  localparam int unsigned FLAG_SIGN   = 4;
  localparam int unsigned FLAG_ZERO   = 3;
  localparam int unsigned FLAG_CARRY  = 2;
  localparam int unsigned FLAG_PARITY = 1;
  localparam int unsigned FLAG_OVF    = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    RESP = 2'd2
  } state_e;

  // Response payload held while rsp_valid is high
  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [DATA_W-1:0] sum;
    logic [FLAG_W-1:0] flags;
  } rsp_t;

endpackage

// File: rtl/adder_arbiter_if.sv
// Requester/consumer bundle of the adder arbiter.
interface adder_arbiter_if
  import adder_arbiter_pkg::*;
;
  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ*DATA_W-1:0] req_a;
  logic [N_REQ*DATA_W-1:0] req_b;
  logic [N_REQ-1:0]        req_ready;
  logic                    rsp_valid;
  logic                    rsp_ready;
  logic [ID_W-1:0]         rsp_id;
  logic [DATA_W-1:0]       rsp_sum;
  logic [FLAG_W-1:0]       rsp_flags;
  logic                    busy;

  // Arbiter side
  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_sum, rsp_flags, busy
  );

  // Requesters and result consumer side
  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_sum, rsp_flags, busy
  );

endinterface

// File: rtl/beh_16bitadder.sv
// Combinational 16-bit adder producing the sum and its status flags.
module beh_16bitadder
  import adder_arbiter_pkg::*;
(
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic [DATA_W-1:0] sum_o,
  output logic [FLAG_W-1:0] flags_o
);

  localparam int unsigned SUM_W = DATA_W + 1;

  logic [SUM_W-1:0] full;

  // Unsigned add with carry-out, then derive flags from the truncated sum
  always_comb begin
    full    = SUM_W'(a_i) + SUM_W'(b_i);
    sum_o   = full[DATA_W-1:0];
    flags_o = '0;
    flags_o[FLAG_SIGN]   = full[DATA_W-1];
    flags_o[FLAG_ZERO]   = (full[DATA_W-1:0] == '0);
    flags_o[FLAG_CARRY]  = full[DATA_W];
    flags_o[FLAG_PARITY] = ~^full[DATA_W-1:0];
    flags_o[FLAG_OVF]    = (a_i[DATA_W-1] == b_i[DATA_W-1]) &&
                           (full[DATA_W-1] != a_i[DATA_W-1]);
  end

endmodule

// File: rtl/adder_arbiter.sv
// Round-robin arbiter sharing one adder among N_REQ requesters.
// One operation in flight: IDLE accepts, CALC adds, RESP holds the result.
module adder_arbiter
  import adder_arbiter_pkg::*;
#(
  parameter int unsigned N_REQ = 4
) (
  input logic           clk,
  input logic           rst_n,
  adder_arbiter_if.slave bus
);

  localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  ptr_q, ptr_d;
  logic [DATA_W-1:0] op_a_q, op_a_d;
  logic [DATA_W-1:0] op_b_q, op_b_d;
  rsp_t              rsp_q, rsp_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              busy_q, busy_d;

  logic              grant_found;
  logic [IDX_W-1:0]  grant_idx;
  logic [N_REQ-1:0]  req_ready_c;
  logic [DATA_W-1:0] add_sum;
  logic [FLAG_W-1:0] add_flags;
  logic [DATA_W-1:0] req_a_arr [N_REQ];
  logic [DATA_W-1:0] req_b_arr [N_REQ];

  // Split the flat operand buses into per-requester words
  for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
    assign req_a_arr[g] = bus.req_a[g*DATA_W +: DATA_W];
    assign req_b_arr[g] = bus.req_b[g*DATA_W +: DATA_W];
  end

  // Round-robin pick: first valid requester at or after ptr_q
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      if (!grant_found && bus.req_valid[IDX_W'((32'(ptr_q) + k) % N_REQ)]) begin
        grant_found = 1'b1;
        grant_idx   = IDX_W'((32'(ptr_q) + k) % N_REQ);
      end
    end
  end

  // Single shared adder fed from the captured operands
  beh_16bitadder u_adder (
    .a_i     (op_a_q),
    .b_i     (op_b_q),
    .sum_o   (add_sum),
    .flags_o (add_flags)
  );

  // Next-state, datapath capture and accept strobe
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    rsp_d       = rsp_q;
    rsp_valid_d = rsp_valid_q;
    req_ready_c = '0;

    unique case (state_q)
      IDLE: begin
        if (grant_found) begin
          req_ready_c[grant_idx] = 1'b1;
          op_a_d   = req_a_arr[grant_idx];
          op_b_d   = req_b_arr[grant_idx];
          rsp_d.id = ID_W'(grant_idx);
          ptr_d    = IDX_W'((32'(grant_idx) + 32'd1) % N_REQ);
          state_d  = CALC;
        end
      end
      CALC: begin
        rsp_d.sum   = add_sum;
        rsp_d.flags = add_flags;
        rsp_valid_d = 1'b1;
        state_d     = RESP;
      end
      RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and datapath registers; reset drops any operation in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      rsp_q       <= '0;
      rsp_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      rsp_q       <= rsp_d;
      rsp_valid_q <= rsp_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.req_ready = req_ready_c;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_q.id;
  assign bus.rsp_sum   = rsp_q.sum;
  assign bus.rsp_flags = rsp_q.flags;
  assign bus.busy      = busy_q;

endmodule
